// File: rtl/sram_mem_pkg.sv
// Shared types and default constants for the MEM-stage SRAM controller.
package sram_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_WAIT_CYCLES = 5;
  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned HALF_W          = 16;
  localparam int unsigned DATA_W          = 32;

endpackage

// File: rtl/sram_mem_stage_wait_timer.sv
// Phase wait counter: clear/enable control, flags the last cycle of a phase.
module sram_wait_timer
  import sram_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count_nxt_c,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_comb begin
    count_nxt_c = count;
    if (clear)       count_nxt_c = '0;
    else if (enable) count_nxt_c = count + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_nxt_c;
  end

  assign last = (count == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_stage.sv
// MEM-stage SRAM controller: each 32-bit access runs as two 16-bit half-word phases.
// Optional access statistics (rd_count/wr_count) are built when SRAM_STATS_EN is defined.
module sram_mem_stage
  import sram_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
`ifdef SRAM_STATS_EN
  ,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
`endif
);

  localparam int unsigned IDX_W = SRAM_AW - 1;
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES);

  state_t             state, state_nxt;
  logic               request;
  logic               clear, enable, last;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [31:0]        offset;
  logic [IDX_W-1:0]   idx_in, idx_q, cur_idx;
  logic [DATA_W-1:0]  wdata_q, cur_wdata;
  logic               wr_q, cur_wr;
  logic               phase_nxt, we_n_nxt, oe_nxt;

  assign request = rd_en | wr_en;
  assign ready   = ~request | (state == DONE);
  assign offset  = address - 32'(BASE_ADDR);
  assign idx_in  = IDX_W'(offset >> 2);

  // Operation is sampled from the inputs in IDLE and held for the rest of the access.
  assign cur_wr    = (state == IDLE) ? wr_en      : wr_q;
  assign cur_idx   = (state == IDLE) ? idx_in     : idx_q;
  assign cur_wdata = (state == IDLE) ? write_data : wdata_q;

  sram_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .enable      (enable),
    .count_nxt_c (cnt_nxt),
    .last        (last)
  );

  always_comb begin
    state_nxt = state;
    clear     = 1'b1;
    enable    = 1'b0;
    case (state)
      IDLE: if (request) state_nxt = LO;
      LO: begin
        if (last) state_nxt = HI;
        else begin
          clear  = 1'b0;
          enable = 1'b1;
        end
      end
      HI: begin
        if (last) state_nxt = DONE;
        else begin
          clear  = 1'b0;
          enable = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM pins are registered from next-state so they line up with each phase cycle.
  assign phase_nxt = (state_nxt == LO) || (state_nxt == HI);
  assign oe_nxt    = cur_wr & phase_nxt;
  assign we_n_nxt  = ~(oe_nxt & (cnt_nxt != CNT_W'(WAIT_CYCLES - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state      <= state_nxt;
      sram_dq_oe <= oe_nxt;
      sram_we_n  <= we_n_nxt;
      if (state == IDLE) begin
        wr_q    <= wr_en;
        idx_q   <= idx_in;
        wdata_q <= write_data;
      end
      if (state_nxt == LO)      sram_addr <= {cur_idx, 1'b0};
      else if (state_nxt == HI) sram_addr <= {cur_idx, 1'b1};
      if (cur_wr && state_nxt == LO)      sram_dq_out <= cur_wdata[HALF_W-1:0];
      else if (cur_wr && state_nxt == HI) sram_dq_out <= cur_wdata[DATA_W-1:HALF_W];
      if (!wr_q && last && state == LO) read_data[HALF_W-1:0]      <= sram_dq_in;
      if (!wr_q && last && state == HI) read_data[DATA_W-1:HALF_W] <= sram_dq_in;
    end
  end

`ifdef SRAM_STATS_EN
  // Saturating access counters, bumped on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == HI && last) begin
      if (wr_q && wr_count != 16'hFFFF)  wr_count <= wr_count + 16'd1;
      if (!wr_q && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_mem_stage.sv
// Directed self-checking bench for sram_mem_stage with a behavioural 16-bit SRAM.
module tb_sram_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;
`ifdef SRAM_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  logic [15:0] mem [0:63];
  int passed = 0;
  int total  = 0;
  int stalls, we_low, we_runs;
  logic oe_seen, done;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  sram_mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
`ifdef SRAM_STATS_EN
    ,
    .rd_count    (rd_count),
    .wr_count    (wr_count)
`endif
  );

  assign sram_dq_in = mem[sram_addr[5:0]];

  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access from IDLE, observed each cycle until ready rises (bounded).
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
    logic prev_we_n;
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = addr; write_data = data;
    stalls = 0; we_low = 0; we_runs = 0; oe_seen = 1'b0; done = 1'b0; prev_we_n = 1'b1;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (sram_dq_oe) oe_seen = 1'b1;
      if (!sram_we_n) begin
        we_low++;
        if (prev_we_n) we_runs++;
      end
      prev_we_n = sram_we_n;
      if (ready) begin
        done  = 1'b1;
        rdata = read_data;
        rd_en = 1'b0;
        wr_en = 1'b0;
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, idle ready
    #1;
    check("rst_read_data", read_data, 32'h0);
    check("rst_we_n", 32'(sram_we_n), 32'h1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("idle_ready", 32'(ready), 32'h1);
    end

    // Write 0x12345678 to 1028
    access(1'b0, 1'b1, 32'd1028, 32'h12345678);
    check("wr_done", 32'(done), 32'h1);
    check("wr_stalls", 32'(stalls), 32'd11);
    check("wr_we_low", 32'(we_low), 32'd8);
    check("wr_we_runs", 32'(we_runs), 32'd2);
    check("wr_mem2", 32'(mem[2]), 32'h5678);
    check("wr_mem3", 32'(mem[3]), 32'h1234);

    // Read it back
    access(1'b1, 1'b0, 32'd1028, 32'h0);
    check("rd_done", 32'(done), 32'h1);
    check("rd_stalls", 32'(stalls), 32'd11);
    check("rd_data", rdata, 32'h12345678);
    check("rd_oe", 32'(oe_seen), 32'h0);
    check("rd_we_low", 32'(we_low), 32'd0);

    // Both enables: treated as a write
    access(1'b1, 1'b1, 32'd1024, 32'hAAAA5555);
    check("both_done", 32'(done), 32'h1);
    check("both_mem0", 32'(mem[0]), 32'h5555);
    check("both_mem1", 32'(mem[1]), 32'hAAAA);
    check("both_rd_hold", read_data, 32'h12345678);

    // Reset during HI of a write
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
    repeat (7) @(negedge clk);
    #1;
    check("mid_hi_we_n", 32'(sram_we_n), 32'h0);
    rst = 1'b1;
    #1;
    check("mid_rst_we_n", 32'(sram_we_n), 32'h1);
    check("mid_rst_oe", 32'(sram_dq_oe), 32'h0);
    check("mid_rst_addr", 32'(sram_addr), 32'h0);
    check("mid_rst_rdata", read_data, 32'h0);
`ifdef SRAM_STATS_EN
    check("mid_rst_wr_count", 32'(wr_count), 32'h0);
`endif
    wr_en = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    access(1'b1, 1'b0, 32'd1024, 32'h0);
    check("post_rst_done", 32'(done), 32'h1);
    check("post_rst_stalls", 32'(stalls), 32'd11);
    check("post_rst_data", rdata, 32'hAAAA5555);

`ifdef SRAM_STATS_EN
    access(1'b0, 1'b1, 32'd1032, 32'h11112222);
    access(1'b0, 1'b1, 32'd1036, 32'h33334444);
    access(1'b0, 1'b1, 32'd1040, 32'h55556666);
    access(1'b1, 1'b0, 32'd1036, 32'h0);
    check("stats_rd_data", rdata, 32'h33334444);
    check("stats_wr_count", 32'(wr_count), 32'd3);
    check("stats_rd_count", 32'(rd_count), 32'd2);
    @(negedge clk);
    force dut.wr_count = 16'hFFFF;
    #1;
    release dut.wr_count;
    access(1'b0, 1'b1, 32'd1044, 32'h77778888);
    check("stats_wr_sat", 32'(wr_count), 32'hFFFF);
    check("stats_rd_keep", 32'(rd_count), 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
